wired_inst_queue: RTL and testbench

WIRED_INST_QUEUE -- requirements
Module: wired_inst_queue

---
 rtl/wired_inst_queue.sv | 109 ++++++++++
 tb/tb_wired_inst_queue.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/wired_inst_queue.sv
// Instruction queue between decode and rename. Accepts decoded pairs from the
// frontend and presents up to two of the oldest instructions to the backend.
// The output is driven from registered state only, so there is always one
// cycle from enqueue to presentation.

package wired_inst_queue_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } pipeline_ctrl_pack_t;

endpackage

module wired_inst_queue
  import wired_inst_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush_i,
  input  logic                      in_valid_i,
  input  logic [1:0]                in_mask_i,
  input  pipeline_ctrl_pack_t [1:0] in_pkg_i,
  output logic                      in_ready_o,
  output logic                      pkg_valid_o,
  input  logic                      pkg_ready_i,
  output logic [1:0]                pkg_mask_o,
  output pipeline_ctrl_pack_t [1:0] pkg_o,
  output logic [$clog2(DEPTH):0]    count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  pipeline_ctrl_pack_t mem_q [DEPTH];

  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_nx, wptr_nx;
  logic [CW-1:0] count_q, count_d;
  logic          enq, deq;
  logic [1:0]    n_in, n_out;

  // Outputs depend only on registered state: no bypass from the input side.
  always_comb begin
    in_ready_o  = (count_q <= CW'(DEPTH - 2));
    pkg_valid_o = (count_q != '0);
    if (count_q >= CW'(2)) begin
      pkg_mask_o = 2'b11;
    end else if (count_q == CW'(1)) begin
      pkg_mask_o = 2'b01;
    end else begin
      pkg_mask_o = 2'b00;
    end
    rptr_nx  = rptr_q + PW'(1);
    wptr_nx  = wptr_q + PW'(1);
    pkg_o[0] = mem_q[rptr_q];
    pkg_o[1] = mem_q[rptr_nx];
    count_o  = count_q;
  end

  // Handshakes, entry counts and next pointer/occupancy state.
  always_comb begin
    enq     = in_valid_i && in_ready_o;
    deq     = pkg_valid_o && pkg_ready_i;
    n_in    = enq ? ({1'b0, in_mask_i[0]} + {1'b0, in_mask_i[1]}) : 2'b00;
    n_out   = deq ? ({1'b0, pkg_mask_o[0]} + {1'b0, pkg_mask_o[1]}) : 2'b00;
    rptr_d  = rptr_q + PW'(n_out);
    wptr_d  = wptr_q + PW'(n_in);
    count_d = count_q + CW'(n_in) - CW'(n_out);
    // A redirect discards everything, including this cycle's traffic.
    if (flush_i) begin
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
    end
  end

  // Pointer and occupancy registers; reset drops everything asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  // Storage write; mask 2'b10 is compacted so slot 1 lands at the write pointer.
  always_ff @(posedge clk) begin
    if (enq && !flush_i) begin
      case (in_mask_i)
        2'b11: begin
          mem_q[wptr_q]  <= in_pkg_i[0];
          mem_q[wptr_nx] <= in_pkg_i[1];
        end
        2'b01:   mem_q[wptr_q] <= in_pkg_i[0];
        2'b10:   mem_q[wptr_q] <= in_pkg_i[1];
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wired_inst_queue.sv
// Directed bench for wired_inst_queue with DEPTH = 8. Inputs change 1 ns after
// the rising edge and outputs are sampled at that same point.

module tb_wired_inst_queue;
  import wired_inst_queue_pkg::*;

  logic                      clk;
  logic                      rst;
  logic                      flush_i;
  logic                      in_valid_i;
  logic [1:0]                in_mask_i;
  pipeline_ctrl_pack_t [1:0] in_pkg_i;
  logic                      in_ready_o;
  logic                      pkg_valid_o;
  logic                      pkg_ready_i;
  logic [1:0]                pkg_mask_o;
  pipeline_ctrl_pack_t [1:0] pkg_o;
  logic [3:0]                count_o;

  int n_cmp = 0;
  int n_bad = 0;

  wired_inst_queue #(
    .DEPTH(8)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (flush_i),
    .in_valid_i (in_valid_i),
    .in_mask_i  (in_mask_i),
    .in_pkg_i   (in_pkg_i),
    .in_ready_o (in_ready_o),
    .pkg_valid_o(pkg_valid_o),
    .pkg_ready_i(pkg_ready_i),
    .pkg_mask_o (pkg_mask_o),
    .pkg_o      (pkg_o),
    .count_o    (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic pipeline_ctrl_pack_t mk(input int id);
    pipeline_ctrl_pack_t p;
    p.pc   = 32'(id) << 2;
    p.inst = 32'hC0DE_0000 | 32'(id);
    return p;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    flush_i     = 1'b0;
    in_valid_i  = 1'b0;
    in_mask_i   = 2'b00;
    in_pkg_i    = '0;
    pkg_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic enq(input logic [1:0] mask, input int id0, input int id1);
    in_valid_i  = 1'b1;
    in_mask_i   = mask;
    in_pkg_i[0] = mk(id0);
    in_pkg_i[1] = mk(id1);
    tick();
    in_valid_i = 1'b0;
    in_mask_i  = 2'b00;
  endtask

  task automatic deq();
    pkg_ready_i = 1'b1;
    tick();
    pkg_ready_i = 1'b0;
  endtask

  task automatic check_state(input string tag, input int cnt, input logic [1:0] mask,
                             input logic valid, input logic ready);
    check({tag, ".count"}, 64'(count_o), 64'(cnt));
    check({tag, ".mask"}, 64'(pkg_mask_o), 64'(mask));
    check({tag, ".valid"}, 64'(pkg_valid_o), 64'(valid));
    check({tag, ".in_ready"}, 64'(in_ready_o), 64'(ready));
  endtask

  initial begin
    // Reset values.
    do_reset();
    check_state("reset", 0, 2'b00, 1'b0, 1'b1);

    // Full pair into empty queue, then drain it.
    enq(2'b11, 1, 2);
    check_state("pair", 2, 2'b11, 1'b1, 1'b1);
    check("pair.slot0", 64'(pkg_o[0]), 64'(mk(1)));
    check("pair.slot1", 64'(pkg_o[1]), 64'(mk(2)));
    deq();
    check_state("pair_drained", 0, 2'b00, 1'b0, 1'b1);

    // Mask 10 compacts; stalled output grows 01 -> 11; empty mask is a no-op.
    do_reset();
    enq(2'b10, 99, 3);
    check_state("m10", 1, 2'b01, 1'b1, 1'b1);
    check("m10.slot0", 64'(pkg_o[0]), 64'(mk(3)));
    enq(2'b01, 4, 98);
    check_state("grow", 2, 2'b11, 1'b1, 1'b1);
    check("grow.slot0", 64'(pkg_o[0]), 64'(mk(3)));
    check("grow.slot1", 64'(pkg_o[1]), 64'(mk(4)));
    enq(2'b00, 97, 96);
    check_state("noop", 2, 2'b11, 1'b1, 1'b1);

    // Fill to capacity with the backend stalled.
    do_reset();
    enq(2'b11, 10, 11);
    enq(2'b11, 12, 13);
    enq(2'b11, 14, 15);
    check_state("fill6", 6, 2'b11, 1'b1, 1'b1);
    enq(2'b11, 16, 17);
    check_state("fill8", 8, 2'b11, 1'b1, 1'b0);
    check("fill8.slot0", 64'(pkg_o[0]), 64'(mk(10)));

    // Seven entries already blocks a pair; a refused offer changes nothing.
    do_reset();
    enq(2'b11, 30, 31);
    enq(2'b11, 32, 33);
    enq(2'b11, 34, 35);
    enq(2'b01, 36, 0);
    check_state("cnt7", 7, 2'b11, 1'b1, 1'b0);
    enq(2'b11, 37, 38);
    check_state("cnt7_refused", 7, 2'b11, 1'b1, 1'b0);
    check("cnt7.slot0", 64'(pkg_o[0]), 64'(mk(30)));

    // Simultaneous enqueue/dequeue at count 6 with the pair split across the wrap.
    do_reset();
    enq(2'b01, 20, 0);
    deq();
    enq(2'b11, 21, 22);
    enq(2'b11, 23, 24);
    enq(2'b11, 25, 26);
    check_state("wrap_pre", 6, 2'b11, 1'b1, 1'b1);
    pkg_ready_i = 1'b1;
    enq(2'b11, 27, 28);
    pkg_ready_i = 1'b0;
    check_state("wrap_same", 6, 2'b11, 1'b1, 1'b1);
    check("wrap.a0", 64'(pkg_o[0]), 64'(mk(23)));
    check("wrap.a1", 64'(pkg_o[1]), 64'(mk(24)));
    deq();
    check("wrap.b0", 64'(pkg_o[0]), 64'(mk(25)));
    check("wrap.b1", 64'(pkg_o[1]), 64'(mk(26)));
    deq();
    check("wrap.c0", 64'(pkg_o[0]), 64'(mk(27)));
    check("wrap.c1", 64'(pkg_o[1]), 64'(mk(28)));
    deq();
    check_state("wrap_drained", 0, 2'b00, 1'b0, 1'b1);

    // Flush overrides same-cycle enqueue and dequeue.
    do_reset();
    enq(2'b11, 40, 41);
    enq(2'b11, 42, 43);
    enq(2'b01, 44, 0);
    check_state("flush_pre", 5, 2'b11, 1'b1, 1'b1);
    flush_i     = 1'b1;
    pkg_ready_i = 1'b1;
    enq(2'b11, 45, 46);
    flush_i     = 1'b0;
    pkg_ready_i = 1'b0;
    check_state("flush", 0, 2'b00, 1'b0, 1'b1);

    // Asynchronous reset mid-stream takes effect before the next edge.
    do_reset();
    enq(2'b11, 50, 51);
    enq(2'b01, 52, 0);
    check_state("arst_pre", 3, 2'b11, 1'b1, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_state("arst", 0, 2'b00, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    check_state("arst_post", 0, 2'b00, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
